img_cmd_sequencer: RTL and testbench
====================================

Name: img_cmd_sequencer

Overview:
- Control sequencer for the 8x8 image-processing engine; owns no pixel data.
- Phases: loads 64 pixels from IROM into the external image buffer; accepts host commands over a cmd_valid/busy handshake; tracks the 2x2 operation origin; dispatches 2x2 operations to the external op datapath; streams the buffer out to IRAM.
- Sits between the host/testbench interface and the buffer plus op datapath.

Parameters:
- ORIGIN_RST, 27: reset origin index (row 3, col 3); top-left pixel of the 2x2 window.
- OP_TIMEOUT, 16: max cycles in OP_WAIT before the op is abandoned.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- cmd  in  4  host command code.
- cmd_valid  in  1  command strobe.
- busy  out  1  high = command not accepted.
- rom_rd  out  1  IROM read enable.
- rom_addr  out  6  IROM address.
- buf_ld  out  1  buffer load strobe; buffer captures IROM_Q at buf_ld_addr.
- buf_ld_addr  out  6  buffer load address.
- op_start  out  1  one-cycle op dispatch pulse.
- op_code  out  4  command being dispatched (5..11).
- op_base  out  6  origin index for the op.
- op_done  in  1  datapath completion pulse.
- buf_rd_addr  out  6  buffer read address during write-out; synchronous read, 1-cycle latency.
- ram_valid  out  1  IRAM write strobe.
- ram_addr  out  6  IRAM address.
- done  out  1  one-cycle completion pulse.
- op_err  out  1  sticky timeout flag.

Behaviour:
- Reset values:
  - state=LOAD, busy=1, origin=ORIGIN_RST, rom_addr=0.
  - rom_rd, buf_ld, op_start, ram_valid, done, op_err all 0.
  - buf_ld_addr, op_code, op_base, buf_rd_addr, ram_addr all 0.
- Reset mid-operation aborts every phase, returns to LOAD, and the IROM load restarts from 0.
- States: LOAD, IDLE, SHIFT, OP_REQ, OP_WAIT, WR, FIN.
- LOAD:
  - rom_rd=1 for 64 cycles with rom_addr 0..63.
  - buf_ld=1 one cycle later, buf_ld_addr = previous rom_addr.
  - After buf_ld for addr 63, go to IDLE; busy falls that cycle, so busy is low exactly 66 cycles after reset release.
  - rom_rd=0 once addr 63 has been issued.
- IDLE:
  - busy=0.
  - A command is accepted only when cmd_valid=1 && busy=0; busy is high the following cycle.
  - cmd_valid while busy=1 is ignored, with no queuing.
- Commands:
  - 0: write-out, go to WR.
  - 1 up, 2 down, 3 left, 4 right: go to SHIFT.
  - 5..11: go to OP_REQ.
  - 12..15: go to SHIFT as a NOP (origin unchanged).
- SHIFT:
  - Lasts 1 cycle with busy=1; origin is updated on entry, then return to IDLE.
  - Origin is row*8+col with row, col in 0..6.
  - up: -8 unless row=0; down: +8 unless row=6; left: -1 unless col=0; right: +1 unless col=6.
  - At a boundary the origin holds.
- OP_REQ:
  - 1 cycle; op_start=1, op_code=cmd, op_base=origin.
  - op_code and op_base are held stable until return to IDLE; then go to OP_WAIT.
- OP_WAIT:
  - op_done=1 returns to IDLE next cycle.
  - op_done is sampled only in OP_WAIT; a pulse in any other state is ignored.
  - A cycle counter starts at 1 on entry. If OP_TIMEOUT cycles pass without op_done: set op_err (sticky until reset) and return to IDLE.
- WR:
  - buf_rd_addr steps 0..63, one per cycle.
  - ram_valid=1 and ram_addr=buf_rd_addr delayed 1 cycle, so 64 consecutive ram_valid cycles.
  - done=1 in the cycle after the last ram_valid (ram_addr 63); then go to FIN.
- FIN: busy=1, all strobes 0, commands ignored until reset.
- Width rules: all address counters are 6-bit; the WR/LOAD counters stop at 63 and never wrap.

Test Plan:
- Reset, release -> rom_rd high for 64 cycles with rom_addr 0..63; buf_ld trails by 1 cycle; busy=0 at cycle 66; origin=27.
- From reset, cmd=1 four times -> origin 19, 11, 3, 3 (boundary hold); then cmd=3 four times -> 2, 1, 0, 0; each cmd gives busy=1 for exactly 1 cycle.
- cmd=7 at origin 27, op_done returned 3 cycles after op_start -> single op_start pulse with op_code=7, op_base=27; busy low 1 cycle after op_done; cmd_valid during busy has no effect.
- cmd=5 with op_done never asserted -> return to IDLE after 16 cycles, op_err=1 and stays 1 through subsequent commands.
- cmd=0 -> buf_rd_addr 0..63; ram_valid for 64 consecutive cycles, ram_addr 0..63 lagging 1 cycle; done pulse 1 cycle after ram_addr 63; busy stays 1 afterward.
- Reset asserted mid-LOAD (rom_addr=30) and mid-WR -> all outputs at reset values; LOAD restarts from rom_addr 0.

Source files
------------

// File: rtl/img_cmd_sequencer.sv
// +--------------------------------------------------------------------------+
// | img_cmd_sequencer                                                         |
// | Control sequencer for the 8x8 image engine: IROM load, host commands,     |
// | 2x2 origin tracking, op dispatch with timeout, and IRAM write-out.        |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module img_cmd_sequencer #(
   parameter int ORIGIN_RST = 27,
   parameter int OP_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cmd,
   input  logic       cmd_valid,
   output logic       busy,
   output logic       rom_rd,
   output logic [5:0] rom_addr,
   output logic       buf_ld,
   output logic [5:0] buf_ld_addr,
   output logic       op_start,
   output logic [3:0] op_code,
   output logic [5:0] op_base,
   input  logic       op_done,
   output logic [5:0] buf_rd_addr,
   output logic       ram_valid,
   output logic [5:0] ram_addr,
   output logic       done,
   output logic       op_err
);

   localparam int CW = $clog2(OP_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_LOAD, S_IDLE, S_SHIFT, S_OP_REQ, S_OP_WAIT, S_WR, S_FIN
   } state_t;

   state_t        state_q;
   logic [5:0]    origin_q, origin_d;
   logic          busy_q, rom_rd_q, buf_ld_q, op_start_q, ram_valid_q;
   logic          done_q, op_err_q, rd_last_q;
   logic [5:0]    rom_addr_q, buf_ld_addr_q, op_base_q, buf_rd_addr_q, ram_addr_q;
   logic [3:0]    op_code_q;
   logic [CW-1:0] tmo_cnt_q;

   // Origin is row*8+col; each move saturates at the 0..6 window limits.
   always_comb begin
      origin_d = origin_q;
      case (cmd)
         4'd1: if (origin_q[5:3] != 3'd0) origin_d = origin_q - 6'd8;
         4'd2: if (origin_q[5:3] != 3'd6) origin_d = origin_q + 6'd8;
         4'd3: if (origin_q[2:0] != 3'd0) origin_d = origin_q - 6'd1;
         4'd4: if (origin_q[2:0] != 3'd6) origin_d = origin_q + 6'd1;
         default: origin_d = origin_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_LOAD;
         origin_q      <= 6'(ORIGIN_RST);
         busy_q        <= 1'b1;
         rom_rd_q      <= 1'b0;
         rom_addr_q    <= 6'd0;
         buf_ld_q      <= 1'b0;
         buf_ld_addr_q <= 6'd0;
         op_start_q    <= 1'b0;
         op_code_q     <= 4'd0;
         op_base_q     <= 6'd0;
         buf_rd_addr_q <= 6'd0;
         ram_valid_q   <= 1'b0;
         ram_addr_q    <= 6'd0;
         done_q        <= 1'b0;
         op_err_q      <= 1'b0;
         rd_last_q     <= 1'b0;
         tmo_cnt_q     <= '0;
      end else begin
         op_start_q <= 1'b0;
         done_q     <= 1'b0;
         case (state_q)
            S_LOAD: begin
               // Buffer write trails the ROM read by one cycle.
               buf_ld_q      <= rom_rd_q;
               buf_ld_addr_q <= rom_addr_q;
               if (buf_ld_q && buf_ld_addr_q == 6'd63) begin
                  buf_ld_q <= 1'b0;
                  busy_q   <= 1'b0;
                  state_q  <= S_IDLE;
               end else if (rom_rd_q) begin
                  if (rom_addr_q == 6'd63) rom_rd_q <= 1'b0;
                  else                     rom_addr_q <= rom_addr_q + 6'd1;
               end else if (!buf_ld_q) begin
                  rom_rd_q <= 1'b1;
               end
            end
            S_IDLE: begin
               if (cmd_valid) begin
                  busy_q <= 1'b1;
                  if (cmd == 4'd0) begin
                     state_q       <= S_WR;
                     buf_rd_addr_q <= 6'd0;
                     rd_last_q     <= 1'b0;
                  end else if (cmd >= 4'd5 && cmd <= 4'd11) begin
                     state_q    <= S_OP_REQ;
                     op_start_q <= 1'b1;
                     op_code_q  <= cmd;
                     op_base_q  <= origin_q;
                  end else begin
                     state_q  <= S_SHIFT;
                     origin_q <= origin_d;
                  end
               end
            end
            S_SHIFT: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            S_OP_REQ: begin
               tmo_cnt_q <= CW'(1);
               state_q   <= S_OP_WAIT;
            end
            S_OP_WAIT: begin
               if (op_done) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else if (tmo_cnt_q == CW'(OP_TIMEOUT)) begin
                  op_err_q <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= S_IDLE;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + CW'(1);
               end
            end
            S_WR: begin
               if (rd_last_q) begin
                  ram_valid_q <= 1'b0;
                  done_q      <= 1'b1;
                  state_q     <= S_FIN;
               end else begin
                  ram_valid_q <= 1'b1;
                  ram_addr_q  <= buf_rd_addr_q;
                  if (buf_rd_addr_q == 6'd63) rd_last_q <= 1'b1;
                  else                        buf_rd_addr_q <= buf_rd_addr_q + 6'd1;
               end
            end
            S_FIN: begin
               busy_q <= 1'b1;
            end
            default: state_q <= S_FIN;
         endcase
      end
   end

   assign busy        = busy_q;
   assign rom_rd      = rom_rd_q;
   assign rom_addr    = rom_addr_q;
   assign buf_ld      = buf_ld_q;
   assign buf_ld_addr = buf_ld_addr_q;
   assign op_start    = op_start_q;
   assign op_code     = op_code_q;
   assign op_base     = op_base_q;
   assign buf_rd_addr = buf_rd_addr_q;
   assign ram_valid   = ram_valid_q;
   assign ram_addr    = ram_addr_q;
   assign done        = done_q;
   assign op_err      = op_err_q;

endmodule

`default_nettype wire

// File: tb/tb_img_cmd_sequencer.sv
// +--------------------------------------------------------------------------+
// | tb_img_cmd_sequencer                                                      |
// | Directed self-checking bench for img_cmd_sequencer.                       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_img_cmd_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] cmd;
   logic       cmd_valid;
   logic       busy, rom_rd, buf_ld, op_start, op_done, ram_valid, done, op_err;
   logic [5:0] rom_addr, buf_ld_addr, op_base, buf_rd_addr, ram_addr;
   logic [3:0] op_code;

   int n_cmp = 0;
   int n_bad = 0;

   img_cmd_sequencer #(.ORIGIN_RST(27), .OP_TIMEOUT(16)) u_dut (
      .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy),
      .rom_rd(rom_rd), .rom_addr(rom_addr), .buf_ld(buf_ld), .buf_ld_addr(buf_ld_addr),
      .op_start(op_start), .op_code(op_code), .op_base(op_base), .op_done(op_done),
      .buf_rd_addr(buf_rd_addr), .ram_valid(ram_valid), .ram_addr(ram_addr),
      .done(done), .op_err(op_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_rst(input string t);
      chk({t, "_busy"}, 32'(busy), 1);
      chk({t, "_rom_rd"}, 32'(rom_rd), 0);
      chk({t, "_rom_addr"}, 32'(rom_addr), 0);
      chk({t, "_buf_ld"}, 32'(buf_ld), 0);
      chk({t, "_buf_ld_addr"}, 32'(buf_ld_addr), 0);
      chk({t, "_op_start"}, 32'(op_start), 0);
      chk({t, "_op_code"}, 32'(op_code), 0);
      chk({t, "_op_base"}, 32'(op_base), 0);
      chk({t, "_buf_rd_addr"}, 32'(buf_rd_addr), 0);
      chk({t, "_ram_valid"}, 32'(ram_valid), 0);
      chk({t, "_ram_addr"}, 32'(ram_addr), 0);
      chk({t, "_done"}, 32'(done), 0);
      chk({t, "_op_err"}, 32'(op_err), 0);
   endtask

   // Expects reset already released at a falling edge.
   task automatic run_load();
      for (int k = 1; k <= 66; k++) begin
         @(negedge clk);
         chk("ld_rom_rd", 32'(rom_rd), 32'(k <= 64));
         chk("ld_rom_addr", 32'(rom_addr), (k > 64) ? 63 : k - 1);
         chk("ld_buf_ld", 32'(buf_ld), 32'(k >= 2 && k <= 65));
         if (k >= 2 && k <= 65) chk("ld_buf_ld_addr", 32'(buf_ld_addr), k - 2);
         chk("ld_busy", 32'(busy), 32'(k < 66));
      end
   endtask

   task automatic send(input logic [3:0] c);
      cmd       = c;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd       = 4'd0;
   endtask

   task automatic shift(input logic [3:0] c);
      send(c);
      chk("shift_busy_hi", 32'(busy), 1);
      @(negedge clk);
      chk("shift_busy_lo", 32'(busy), 0);
   endtask

   // Reads the current origin back through an op dispatch.
   task automatic probe(input int exp);
      send(4'd11);
      chk("probe_start", 32'(op_start), 1);
      chk("probe_code", 32'(op_code), 11);
      chk("probe_base", 32'(op_base), 32'(exp));
      @(negedge clk);
      chk("probe_start_lo", 32'(op_start), 0);
      op_done = 1'b1;
      @(negedge clk);
      op_done = 1'b0;
      chk("probe_idle", 32'(busy), 0);
   endtask

   initial begin
      int n;
      reset = 1'b1; cmd = 4'd0; cmd_valid = 1'b0; op_done = 1'b0;
      repeat (3) @(negedge clk);
      chk_rst("rst");
      reset = 1'b0;
      run_load();

      // Op with completion 3 cycles after dispatch; a command during busy is dropped.
      send(4'd7);
      chk("op7_start", 32'(op_start), 1);
      chk("op7_code", 32'(op_code), 7);
      chk("op7_base", 32'(op_base), 27);
      cmd = 4'd2; cmd_valid = 1'b1;
      @(negedge clk);
      chk("op7_single_pulse", 32'(op_start), 0);
      @(negedge clk);
      chk("op7_busy", 32'(busy), 1);
      @(negedge clk);
      op_done = 1'b1; cmd_valid = 1'b0; cmd = 4'd0;
      @(negedge clk);
      op_done = 1'b0;
      chk("op7_idle", 32'(busy), 0);
      chk("op7_code_hold", 32'(op_code), 7);
      probe(27);

      shift(4'd1); probe(19);
      shift(4'd1); probe(11);
      shift(4'd1); probe(3);
      shift(4'd1); probe(3);
      shift(4'd3); probe(2);
      shift(4'd3); probe(1);
      shift(4'd3); probe(0);
      shift(4'd3); probe(0);
      shift(4'd12); probe(0);
      shift(4'd4); probe(1);
      shift(4'd2); probe(9);

      // Stray op_done in IDLE must not disturb anything.
      op_done = 1'b1;
      @(negedge clk);
      op_done = 1'b0;
      chk("stray_done_busy", 32'(busy), 0);

      chk("err_before", 32'(op_err), 0);
      send(4'd5);
      chk("tmo_start", 32'(op_start), 1);
      n = 0;
      while (busy && n < 40) begin
         n++;
         @(negedge clk);
      end
      chk("tmo_busy_cycles", 32'(n), 17);
      chk("tmo_err", 32'(op_err), 1);
      shift(4'd3);
      probe(8);
      chk("err_sticky", 32'(op_err), 1);

      // Write-out.
      send(4'd0);
      chk("wr_rd0", 32'(buf_rd_addr), 0);
      chk("wr_valid0", 32'(ram_valid), 0);
      for (int i = 1; i <= 64; i++) begin
         @(negedge clk);
         chk("wr_valid", 32'(ram_valid), 1);
         chk("wr_addr", 32'(ram_addr), 32'(i - 1));
         chk("wr_rd", 32'(buf_rd_addr), (i > 63) ? 63 : i);
         chk("wr_done_early", 32'(done), 0);
      end
      @(negedge clk);
      chk("wr_valid_end", 32'(ram_valid), 0);
      chk("wr_done", 32'(done), 1);
      send(4'd1);
      chk("fin_done_lo", 32'(done), 0);
      chk("fin_busy", 32'(busy), 1);
      @(negedge clk);
      chk("fin_busy2", 32'(busy), 1);
      chk("fin_valid", 32'(ram_valid), 0);

      // Reset mid-LOAD.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n = 0;
      while (rom_addr != 6'd30 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("reach_addr30", 32'(rom_addr), 30);
      reset = 1'b1;
      #1;
      chk_rst("midload");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("reload_rd", 32'(rom_rd), 1);
      chk("reload_addr0", 32'(rom_addr), 0);
      @(negedge clk);
      chk("reload_addr1", 32'(rom_addr), 1);
      n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("reload_idle", 32'(busy), 0);

      // Reset mid-WR.
      send(4'd0);
      repeat (10) @(negedge clk);
      chk("midwr_active", 32'(ram_valid), 1);
      reset = 1'b1;
      #1;
      chk_rst("midwr");
      @(negedge clk);
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
